sr_flag_arbiter: RTL and testbench

Round-robin arbiter that shares a bank of NFLAG set/reset status flags among NREQ requesters. Each requester asks to set or clear one flag. The arbiter grants one request per cycle and converts it into a one-cycle set or reset pulse on the internal SR flag bank. This guarantees the forbidden s=r=1 input never reaches any flag cell. It sits between control agents and the shared status flags read by the rest of the sequential design.

---
 rtl/sr_flag_pkg.sv | 25 ++
 rtl/sr_flag_arbiter_if.sv | 18 +
 rtl/sr_flag_arbiter_sr_cell.sv | 37 +++
 rtl/sr_flag_arbiter.sv | 136 +++++++++++++
 tb/tb_sr_flag_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sr_flag_pkg.sv
// Shared definitions for the SR flag arbiter: op encoding, default sizes,
// the granted-command bundle and a small round-robin helper.
package sr_flag_pkg;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_NFLAG = 8;

  // Widest index the bank supports (NFLAG up to 32).
  localparam int MAX_IDXW = 5;

  // One granted request: operation plus zero-extended flag index.
  typedef struct packed {
    logic                op;
    logic [MAX_IDXW-1:0] idx;
  } flag_cmd_t;

  // Pointer value following requester w in a ring of n requesters.
  function automatic int rr_inc(input int w, input int n);
    return (w + 1 >= n) ? 0 : w + 1;
  endfunction

endpackage

// File: rtl/sr_flag_arbiter_if.sv
// Request/grant bundle between the control agents and the flag arbiter.
interface sr_flag_arbiter_if
  import sr_flag_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDXW = $clog2(DEF_NFLAG)
);

  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      op;
  logic [NREQ*IDXW-1:0] idx;
  logic                 hold;
  logic [NREQ-1:0]      gnt;

  modport master (output req, output op, output idx, output hold, input gnt);
  modport slave  (input req, input op, input idx, input hold, output gnt);

endinterface

// File: rtl/sr_flag_arbiter_sr_cell.sv
// Single synchronous SR status flag; set has priority in the update
// expression but the arbiter never drives s and r together.
module sr_cell (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic qb
);

  logic q_q;
  logic q_d;

  // Next state: set, clear or hold.
  always_comb begin
    q_d = q_q;
    if (s) begin
      q_d = 1'b1;
    end else if (r) begin
      q_d = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter turning set/clear requests into single-cycle pulses
// on a bank of SR flags, one command per cycle through a command register.
module sr_flag_arbiter
  import sr_flag_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int NFLAG = DEF_NFLAG,
  parameter int IDXW  = $clog2(NFLAG)
) (
  input  logic               clk,
  input  logic               rst,
  sr_flag_arbiter_if.slave   bus,
  output logic [NFLAG-1:0]   flags,
  output logic [NFLAG-1:0]   flags_b,
  output logic               err_oor,
  output logic [7:0]         conflict_cnt
);

  localparam int RRW = $clog2(NREQ);

  logic [RRW-1:0]  rr_q, rr_d;
  logic            cmd_v_q, cmd_v_d;
  flag_cmd_t       cmd_q, cmd_d;
  logic            err_oor_q, err_oor_d;
  logic [7:0]      conflict_cnt_q, conflict_cnt_d;

  logic [NREQ-1:0] gnt_c;
  logic [RRW-1:0]  win;
  logic            found;
  logic            grant;
  int              cand;
  flag_cmd_t       sel_cmd;
  logic            conflict;

  logic [NFLAG-1:0] cell_s;
  logic [NFLAG-1:0] cell_r;

  // Pick the first requesting agent at or after the pointer, wrapping.
  always_comb begin
    gnt_c = '0;
    win   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = RRW'(cand);
      end
    end
    grant = found && !bus.hold && !rst;
    if (grant) begin
      gnt_c[win] = 1'b1;
    end
  end

  assign bus.gnt = gnt_c;

  // Extract the winner's op and index into the command bundle.
  always_comb begin
    sel_cmd               = '0;
    sel_cmd.op            = bus.op[win];
    sel_cmd.idx[IDXW-1:0] = bus.idx[int'(win)*IDXW +: IDXW];
  end

  // Flag any pair of pending requests that target one index with opposite ops.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = i + 1; j < NREQ; j++) begin
        if (bus.req[i] && bus.req[j] && (bus.op[i] != bus.op[j]) &&
            (bus.idx[i*IDXW +: IDXW] == bus.idx[j*IDXW +: IDXW])) begin
          conflict = 1'b1;
        end
      end
    end
  end

  // Next values for pointer, command stage, error pulse and conflict counter.
  always_comb begin
    rr_d           = rr_q;
    cmd_v_d        = grant;
    cmd_d          = cmd_q;
    err_oor_d      = 1'b0;
    conflict_cnt_d = conflict_cnt_q;
    if (grant) begin
      rr_d      = RRW'(rr_inc(int'(win), NREQ));
      cmd_d     = sel_cmd;
      err_oor_d = (int'(sel_cmd.idx) >= NFLAG);
    end
    if (conflict && (conflict_cnt_q != 8'hFF)) begin
      conflict_cnt_d = conflict_cnt_q + 8'd1;
    end
  end

  // Registers; reset also discards any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q           <= '0;
      cmd_v_q        <= 1'b0;
      cmd_q          <= '0;
      err_oor_q      <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      rr_q           <= rr_d;
      cmd_v_q        <= cmd_v_d;
      cmd_q          <= cmd_d;
      err_oor_q      <= err_oor_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign err_oor      = err_oor_q;
  assign conflict_cnt = conflict_cnt_q;

  // Decode the command into a set or clear strobe on exactly one cell;
  // out-of-range indices match no cell.
  for (genvar gi = 0; gi < NFLAG; gi++) begin : g_cell
    assign cell_s[gi] = cmd_v_q && (cmd_q.op == OP_SET) &&
                        (cmd_q.idx == MAX_IDXW'(gi));
    assign cell_r[gi] = cmd_v_q && (cmd_q.op == OP_CLR) &&
                        (cmd_q.idx == MAX_IDXW'(gi));
    sr_cell u_cell (
      .clk (clk),
      .rst (rst),
      .s   (cell_s[gi]),
      .r   (cell_r[gi]),
      .q   (flags[gi]),
      .qb  (flags_b[gi])
    );
  end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed and randomized checks of the SR flag arbiter against a
// cycle-level model of the arbitration and flag rules.
module tb_sr_flag_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  sr_flag_arbiter_if #(.NREQ(4), .IDXW(3)) if8 ();
  sr_flag_arbiter_if #(.NREQ(4), .IDXW(3)) if6 ();

  logic [7:0] flags8, flags8_b;
  logic       err8;
  logic [7:0] cnt8;
  logic [5:0] flags6, flags6_b;
  logic       err6;
  logic [7:0] cnt6;

  sr_flag_arbiter #(.NREQ(4), .NFLAG(8)) dut8 (
    .clk(clk), .rst(rst), .bus(if8.slave),
    .flags(flags8), .flags_b(flags8_b), .err_oor(err8), .conflict_cnt(cnt8)
  );

  sr_flag_arbiter #(.NREQ(4), .NFLAG(6)) dut6 (
    .clk(clk), .rst(rst), .bus(if6.slave),
    .flags(flags6), .flags_b(flags6_b), .err_oor(err6), .conflict_cnt(cnt6)
  );

  // Every cycle, no cell may be driven with set and clear together.
  always @(negedge clk) begin
    tests_run++;
    if (((dut8.cell_s & dut8.cell_r) !== 8'h00) || ((dut6.cell_s & dut6.cell_r) !== 6'h00)) begin
      tests_failed++;
      $display("FAIL sr_both got s=%b r=%b required s&r=0", dut8.cell_s, dut8.cell_r);
    end
  end

  task automatic drive8(input logic [3:0] req, input logic [3:0] op,
                        input logic [11:0] idx, input logic hold);
    if8.req = req; if8.op = op; if8.idx = idx; if8.hold = hold;
  endtask

  task automatic drive6(input logic [3:0] req, input logic [3:0] op,
                        input logic [11:0] idx, input logic hold);
    if6.req = req; if6.op = op; if6.idx = idx; if6.hold = hold;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive8(4'h0, 4'h0, 12'h0, 1'b0);
    drive6(4'h0, 4'h0, 12'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive8(4'hF, 4'hF, 12'h688, 1'b0);
    @(negedge clk);
    #1;
    tests_run++;
    if (if8.gnt !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_gnt_during_rst got %b required 0000", if8.gnt);
    end
    drive8(4'h0, 4'h0, 12'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (flags8 !== 8'h00 || flags8_b !== 8'hFF || cnt8 !== 8'd0 || err8 !== 1'b0 || if8.gnt !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_state got flags=%h flags_b=%h cnt=%0d err=%b gnt=%b required 00 ff 0 0 0000",
               flags8, flags8_b, cnt8, err8, if8.gnt);
    end
  endtask

  task automatic test_single_set();
    do_reset();
    @(negedge clk);
    drive8(4'b0010, 4'b0010, 12'h018, 1'b0);
    #1;
    tests_run++;
    if (if8.gnt !== 4'b0010) begin
      tests_failed++;
      $display("FAIL single_gnt got %b required 0010", if8.gnt);
    end
    @(negedge clk);
    drive8(4'h0, 4'h0, 12'h0, 1'b0);
    #1;
    tests_run++;
    if (flags8 !== 8'h00) begin
      tests_failed++;
      $display("FAIL single_latency got %h required 00", flags8);
    end
    @(negedge clk);
    tests_run++;
    if (flags8 !== 8'h08 || flags8_b !== 8'hF7) begin
      tests_failed++;
      $display("FAIL single_flags got %h/%h required 08/f7", flags8, flags8_b);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [5];
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive8(4'hF, 4'hF, 12'h688, 1'b0);
      #1;
      tests_run++;
      if (if8.gnt !== exp_seq[k]) begin
        tests_failed++;
        $display("FAIL rr_gnt[%0d] got %b required %b", k, if8.gnt, exp_seq[k]);
      end
    end
    @(negedge clk);
    drive8(4'h0, 4'h0, 12'h0, 1'b0);
    @(negedge clk);
    tests_run++;
    if (flags8 !== 8'h0F) begin
      tests_failed++;
      $display("FAIL rr_flags got %h required 0f", flags8);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    @(negedge clk);
    drive8(4'b0011, 4'b0001, 12'h02D, 1'b0);
    #1;
    tests_run++;
    if (if8.gnt !== 4'b0001) begin
      tests_failed++;
      $display("FAIL conflict_first got %b required 0001", if8.gnt);
    end
    @(negedge clk);
    drive8(4'b0010, 4'b0000, 12'h028, 1'b0);
    #1;
    tests_run++;
    if (if8.gnt !== 4'b0010 || cnt8 !== 8'd1) begin
      tests_failed++;
      $display("FAIL conflict_second got gnt=%b cnt=%0d required 0010 1", if8.gnt, cnt8);
    end
    @(negedge clk);
    drive8(4'h0, 4'h0, 12'h0, 1'b0);
    #1;
    tests_run++;
    if (flags8 !== 8'h20) begin
      tests_failed++;
      $display("FAIL conflict_mid got %h required 20", flags8);
    end
    @(negedge clk);
    tests_run++;
    if (flags8 !== 8'h00 || cnt8 !== 8'd1) begin
      tests_failed++;
      $display("FAIL conflict_final got flags=%h cnt=%0d required 00 1", flags8, cnt8);
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    @(negedge clk);
    drive6(4'b0001, 4'b0001, 12'h002, 1'b0);
    #1;
    tests_run++;
    if (if6.gnt !== 4'b0001) begin
      tests_failed++;
      $display("FAIL oor_gnt0 got %b required 0001", if6.gnt);
    end
    @(negedge clk);
    tests_run++;
    if (err6 !== 1'b0) begin
      tests_failed++;
      $display("FAIL oor_err_inrange got %b required 0", err6);
    end
    drive6(4'b0010, 4'b0010, 12'h038, 1'b0);
    #1;
    tests_run++;
    if (if6.gnt !== 4'b0010) begin
      tests_failed++;
      $display("FAIL oor_gnt got %b required 0010", if6.gnt);
    end
    @(negedge clk);
    drive6(4'h0, 4'h0, 12'h0, 1'b0);
    #1;
    tests_run++;
    if (err6 !== 1'b1 || flags6 !== 6'h04) begin
      tests_failed++;
      $display("FAIL oor_pulse got err=%b flags=%h required 1 04", err6, flags6);
    end
    @(negedge clk);
    tests_run++;
    if (err6 !== 1'b0 || flags6 !== 6'h04 || flags6_b !== 6'h3B) begin
      tests_failed++;
      $display("FAIL oor_after got err=%b flags=%h/%h required 0 04/3b", err6, flags6, flags6_b);
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive8(4'b0100, 4'b0100, 12'h180, 1'b1);
      #1;
      tests_run++;
      if (if8.gnt !== 4'b0000) begin
        tests_failed++;
        $display("FAIL hold_gnt[%0d] got %b required 0000", k, if8.gnt);
      end
    end
    @(negedge clk);
    drive8(4'b0100, 4'b0100, 12'h180, 1'b0);
    #1;
    tests_run++;
    if (if8.gnt !== 4'b0100) begin
      tests_failed++;
      $display("FAIL hold_release got %b required 0100", if8.gnt);
    end
    @(negedge clk);
    drive8(4'h0, 4'h0, 12'h0, 1'b1);
    @(negedge clk);
    tests_run++;
    if (flags8 !== 8'h40) begin
      tests_failed++;
      $display("FAIL hold_no_squash got %h required 40", flags8);
    end
    drive8(4'h0, 4'h0, 12'h0, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    drive8(4'b0001, 4'b0001, 12'h007, 1'b0);
    @(negedge clk);
    drive8(4'h0, 4'h0, 12'h0, 1'b0);
    @(negedge clk);
    drive8(4'b1000, 4'b1000, 12'h200, 1'b0);
    #1;
    tests_run++;
    if (flags8 !== 8'h80 || if8.gnt !== 4'b1000) begin
      tests_failed++;
      $display("FAIL rstmid_pre got flags=%h gnt=%b required 80 1000", flags8, if8.gnt);
    end
    @(negedge clk);
    rst = 1'b1;
    drive8(4'hF, 4'hF, 12'h688, 1'b0);
    #1;
    tests_run++;
    if (if8.gnt !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rstmid_gnt got %b required 0000", if8.gnt);
    end
    @(negedge clk);
    drive8(4'h0, 4'h0, 12'h0, 1'b0);
    rst = 1'b0;
    #1;
    tests_run++;
    if (flags8 !== 8'h00 || flags8_b !== 8'hFF || cnt8 !== 8'd0 || err8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_state got flags=%h/%h cnt=%0d err=%b required 00/ff 0 0",
               flags8, flags8_b, cnt8, err8);
    end
    @(negedge clk);
    tests_run++;
    if (flags8 !== 8'h00) begin
      tests_failed++;
      $display("FAIL rstmid_discard got %h required 00", flags8);
    end
  endtask

  task automatic test_random();
    bit        pend [4];
    bit        p_op [4];
    int        p_idx [4];
    bit [7:0]  m_flags = 8'h00;
    int        m_rr = 0;
    int        m_cnt = 0;
    bit        prev_v = 1'b0;
    bit        prev_op = 1'b0;
    int        prev_idx = 0;
    logic [3:0]  v_req, v_op, exp_gnt;
    logic [11:0] v_idx;
    logic        v_hold;
    int          w;
    bit          clash;
    int          errs = 0;
    for (int i = 0; i < 4; i++) begin
      pend[i] = 1'b0; p_op[i] = 1'b0; p_idx[i] = 0;
    end
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (flags8 !== m_flags || flags8_b !== ~m_flags || cnt8 !== 8'(m_cnt) || err8 !== 1'b0) begin
        errs++;
        $display("FAIL rand_state cyc=%0d got flags=%h cnt=%0d err=%b required flags=%h cnt=%0d err=0",
                 cyc, flags8, cnt8, err8, m_flags, m_cnt);
      end
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i]  = 1'b1;
          p_op[i]  = 1'($urandom_range(0, 1));
          p_idx[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 3);
        end
      end
      v_hold = ($urandom_range(0, 7) == 0);
      v_idx = '0;
      for (int i = 0; i < 4; i++) begin
        v_req[i] = pend[i];
        v_op[i]  = p_op[i];
        v_idx[i*3 +: 3] = 3'(p_idx[i]);
      end
      drive8(v_req, v_op, v_idx, v_hold);
      #1;
      clash = 1'b0;
      for (int i = 0; i < 4; i++)
        for (int j = i + 1; j < 4; j++)
          if (pend[i] && pend[j] && p_idx[i] == p_idx[j] && p_op[i] != p_op[j]) clash = 1'b1;
      w = -1;
      if (!v_hold) begin
        for (int k = 0; k < 4; k++) begin
          if (w < 0 && pend[(m_rr + k) % 4]) w = (m_rr + k) % 4;
        end
      end
      exp_gnt = 4'b0000;
      if (w >= 0) exp_gnt[w] = 1'b1;
      if (if8.gnt !== exp_gnt) begin
        errs++;
        $display("FAIL rand_gnt cyc=%0d got %b required %b", cyc, if8.gnt, exp_gnt);
      end
      if (prev_v) m_flags[prev_idx] = prev_op;
      prev_v = (w >= 0);
      if (w >= 0) begin
        prev_op  = p_op[w];
        prev_idx = p_idx[w];
        pend[w]  = 1'b0;
        m_rr     = (w + 1) % 4;
      end
      if (clash && m_cnt < 255) m_cnt++;
    end
    tests_run++;
    if (errs != 0) begin
      tests_failed++;
      $display("FAIL rand_summary got %0d bad cycles required 0", errs);
    end
    @(negedge clk);
    drive8(4'h0, 4'h0, 12'h0, 1'b0);
  endtask

  initial begin
    drive8(4'h0, 4'h0, 12'h0, 1'b0);
    drive6(4'h0, 4'h0, 12'h0, 1'b0);
    test_reset();
    test_single_set();
    test_round_robin();
    test_conflict();
    test_out_of_range();
    test_hold();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
